// File: rtl/boron_pkg.sv
// Shared BORON definitions: round count, rotation amount, S-box tables and the nibble
// shuffle used by both the encrypt and decrypt datapaths.
package boron_pkg;

  localparam int NUM_ROUNDS_DEF = 25;
  localparam int ROT_AMT        = 7;

  // Nibble i of each table sits at bits [4i+3:4i].
  localparam logic [63:0] SBOX     = 64'h2174_8FE3_DA09_B65C;
  localparam logic [63:0] INV_SBOX = 64'hA970_364B_D21C_8FE5;

  typedef logic [15:0] word_t;
  typedef logic [63:0] block_t;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return SBOX[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] inv_sbox4(input logic [3:0] x);
    return INV_SBOX[{x, 2'b00} +: 4];
  endfunction

  // The forward shuffle moves source nibble i to nibble (5*i + 3) mod 16.
  function automatic logic [3:0] shuffle_dst(input int i);
    return 4'(5 * i + 3);
  endfunction

  function automatic block_t shuffle(input block_t x);
    block_t r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[{shuffle_dst(i), 2'b00} +: 4] = x[{4'(i), 2'b00} +: 4];
    end
    return r;
  endfunction

  function automatic block_t inv_shuffle(input block_t x);
    block_t r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[{4'(i), 2'b00} +: 4] = x[{shuffle_dst(i), 2'b00} +: 4];
    end
    return r;
  endfunction

endpackage

// File: rtl/boron_inv_round.sv
// One BORON inverse round, purely combinational: inverse XOR mix, rotate right,
// inverse shuffle, inverse S-box on every nibble, then round-key addition.
module boron_inv_round
  import boron_pkg::*;
(
  input  block_t state_i,
  input  block_t rk_i,
  output block_t state_o,
  output block_t mix_o
);

  word_t w0, w1, w2, w3;
  block_t rot, shuf, sub;

  assign {w3, w2, w1, w0} = state_i;

  assign mix_o = {w2 ^ w3, w0 ^ w1 ^ w2, w1 ^ w2 ^ w3, w0 ^ w1};
  assign rot   = (mix_o >> ROT_AMT) | (mix_o << (64 - ROT_AMT));
  assign shuf  = inv_shuffle(rot);

  for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
    assign sub[4*gi +: 4] = inv_sbox4(shuf[4*gi +: 4]);
  end

  assign state_o = sub ^ rk_i;

endmodule

// File: rtl/boron_decrypt_core.sv
// Iterative BORON decryptor, one inverse round per clock with external round keys.
// Define BORON_DEC_ZEROIZE_EN to hide intermediate state and clear it after output.
module boron_decrypt_core
  import boron_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
  parameter int RK_IDX_W   = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [63:0]         data_i,
  output logic [RK_IDX_W-1:0] rk_idx_o,
  input  logic [63:0]         rk_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [63:0]         data_o,
  output logic                busy_o
);

  if (NUM_ROUNDS >= (1 << RK_IDX_W)) begin : g_bad_cfg
    $error("NUM_ROUNDS does not fit in RK_IDX_W bits");
  end

  localparam logic [RK_IDX_W-1:0] WHITEN_IDX = RK_IDX_W'(NUM_ROUNDS);
  localparam logic [RK_IDX_W-1:0] FIRST_RND  = RK_IDX_W'(NUM_ROUNDS - 1);

  fsm_e                fsm_q, fsm_d;
  block_t              state_q, state_d;
  logic [RK_IDX_W-1:0] rnd_q, rnd_d;
  logic [RK_IDX_W-1:0] rk_idx_q, rk_idx_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  block_t              round_out;
  block_t              round_mix;

  boron_inv_round u_inv_round (
    .state_i (state_q),
    .rk_i    (rk_i),
    .state_o (round_out),
    .mix_o   (round_mix)
  );

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    rnd_d       = rnd_q;
    rk_idx_d    = rk_idx_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid_i) begin
          state_d    = data_i ^ rk_i;
          rnd_d      = FIRST_RND;
          rk_idx_d   = FIRST_RND;
          fsm_d      = ROUND;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ROUND: begin
        state_d = round_out;
        if (rnd_q == '0) begin
          fsm_d       = DONE;
          rk_idx_d    = WHITEN_IDX;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
        end else begin
          rnd_d    = rnd_q - 1'b1;
          rk_idx_d = rnd_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          fsm_d       = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
`ifdef BORON_DEC_ZEROIZE_EN
          state_d     = '0;
`endif
        end
      end
      default: begin
        fsm_d       = IDLE;
        rk_idx_d    = WHITEN_IDX;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      rnd_q       <= '0;
      rk_idx_q    <= WHITEN_IDX;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      rk_idx_q    <= rk_idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign rk_idx_o    = rk_idx_q;

`ifdef BORON_DEC_ZEROIZE_EN
  assign data_o = out_valid_q ? state_q : '0;
`else
  assign data_o = state_q;
`endif

  // The mix stage is only observed on the standalone round instance.
  logic unused_mix;
  assign unused_mix = ^round_mix;

endmodule

// File: tb/tb_boron_decrypt_core.sv
// Directed bench for boron_decrypt_core with an independent forward-cipher model.
module tb_boron_decrypt_core;
  localparam int NR = 25;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        out_ready_i = 1'b0;
  logic [63:0] data_i = '0;
  logic        in_ready_o, out_valid_o, busy_o;
  logic [63:0] rk_i, data_o;
  logic [4:0]  rk_idx_o;
  logic [63:0] keys [32];
  logic [63:0] unit_in = '0;
  logic [63:0] unit_out, unit_mix;

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                     4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  always #5 clk_i = ~clk_i;
  assign rk_i = keys[rk_idx_o];

  boron_decrypt_core dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .data_i      (data_i),
    .rk_idx_o    (rk_idx_o),
    .rk_i        (rk_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .data_o      (data_o),
    .busy_o      (busy_o)
  );

  boron_inv_round u_unit (
    .state_i (unit_in),
    .rk_i    (64'h0),
    .state_o (unit_out),
    .mix_o   (unit_mix)
  );

  // Forward cipher model: S-box, shuffle, rotate left 7, XOR mix, then key.
  function automatic logic [63:0] m_round(input logic [63:0] x);
    logic [63:0] s, h, r;
    logic [15:0] x0, x1, x2, x3;
    for (int i = 0; i < 16; i++) s[4*i +: 4] = SB[x[4*i +: 4]];
    h = '0;
    for (int i = 0; i < 16; i++) h[4*((5*i+3)%16) +: 4] = s[4*i +: 4];
    r = (h << 7) | (h >> 57);
    {x3, x2, x1, x0} = r;
    return {x0 ^ x2 ^ x3, x0 ^ x2, x1 ^ x3, x0 ^ x1 ^ x3};
  endfunction

  function automatic logic [63:0] m_mix(input logic [63:0] x);
    logic [15:0] x0, x1, x2, x3;
    {x3, x2, x1, x0} = x;
    return {x0 ^ x2 ^ x3, x0 ^ x2, x1 ^ x3, x0 ^ x1 ^ x3};
  endfunction

  function automatic logic [63:0] m_enc(input logic [63:0] pt);
    logic [63:0] s;
    s = pt;
    for (int r = 0; r < NR; r++) s = m_round(s ^ keys[r]);
    return s ^ keys[NR];
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_keys(input bit zero);
    for (int i = 0; i < 32; i++) keys[i] = (zero || i > NR) ? 64'h0 : rnd64();
  endtask

  task automatic start_block(input logic [63:0] ct, output bit ok);
    int w;
    w = 0;
    while (!in_ready_o && w < 60) begin
      step();
      w++;
    end
    ok = in_ready_o && (rk_idx_o == 5'(NR));
    data_i = ct;
    in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    data_i = rnd64();
  endtask

  task automatic wait_done(output int lat, output bit seq_ok, output logic [63:0] first_data);
    lat = 0;
    seq_ok = 1'b1;
    first_data = data_o;
    while (!out_valid_o && lat < 60) begin
      if (rk_idx_o !== 5'(NR - 1 - lat) || !busy_o || in_ready_o) seq_ok = 1'b0;
      step();
      lat++;
    end
    if (!out_valid_o) lat = -1;
    if (rk_idx_o !== 5'(NR) || busy_o) seq_ok = 1'b0;
  endtask

  task automatic handshake();
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
  endtask

  task automatic full_block(input string tag, input logic [63:0] pt, output logic [63:0] first_data);
    bit ok, seq_ok;
    int lat;
    logic [63:0] ct;
    ct = m_enc(pt);
    start_block(ct, ok);
    wait_done(lat, seq_ok, first_data);
    check({tag, "_accept"}, 64'(ok), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'(NR));
    check({tag, "_rkseq"}, 64'(seq_ok), 64'd1);
    check({tag, "_plain"}, data_o, pt);
    handshake();
  endtask

  initial begin
    logic [63:0] pt, ct, fd, held, v;
    bit ok, stable, seq_ok;
    int lat;

    set_keys(1'b1);
    repeat (3) step();
    check("rst_in_ready", 64'(in_ready_o), 64'd1);
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_data", data_o, 64'h0);
    check("rst_rk_idx", 64'(rk_idx_o), 64'(NR));
    rst_ni = 1'b1;
    step();

    // Standalone inverse round
    unit_in = 64'h0006_0002_0006_0007;
    #1;
    check("unit_invxor", unit_mix, 64'h0004_0003_0002_0001);
    v = rnd64();
    unit_in = m_mix(v);
    #1;
    check("unit_invxor_rand", unit_mix, v);
    unit_in = m_round(v);
    #1;
    check("unit_full_round", unit_out, v);

    // All-zero keys, known plaintext
    full_block("zero_key", 64'h0123_4567_89AB_CDEF, fd);

    // Visibility of intermediate state and retention after handshake
    set_keys(1'b0);
    pt = rnd64();
    ct = m_enc(pt);
    full_block("vis", pt, fd);
`ifdef BORON_DEC_ZEROIZE_EN
    check("vis_round_data", fd, 64'h0);
    check("vis_after_hs", data_o, 64'h0);
`else
    check("vis_round_data", fd, ct ^ keys[NR]);
    check("vis_after_hs", data_o, pt);
`endif

    // Backpressure in DONE
    pt = rnd64();
    start_block(m_enc(pt), ok);
    wait_done(lat, seq_ok, fd);
    held = data_o;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid_i = i[0];
      data_i = rnd64();
      step();
      if (data_o !== held || !out_valid_o || in_ready_o || busy_o) stable = 1'b0;
    end
    in_valid_i = 1'b0;
    check("bp_stable", 64'(stable), 64'd1);
    check("bp_plain", held, pt);
    handshake();
    check("bp_ready_after_hs", 64'(in_ready_o), 64'd1);
    check("bp_valid_after_hs", 64'(out_valid_o), 64'd0);
    pt = rnd64();
    data_i = m_enc(pt);
    in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    check("bp_next_accept", {59'd0, busy_o, rk_idx_o}, {59'd0, 1'b1, 5'(NR - 1)});
    wait_done(lat, seq_ok, fd);
    check("bp_next_plain", data_o, pt);
    handshake();

    // Reset in the middle of round 10
    pt = rnd64();
    start_block(m_enc(pt), ok);
    repeat (10) step();
    rst_ni = 1'b0;
    #1;
    check("midrst_in_ready", 64'(in_ready_o), 64'd1);
    check("midrst_out_valid", 64'(out_valid_o), 64'd0);
    check("midrst_data", data_o, 64'h0);
    check("midrst_rk_idx", 64'(rk_idx_o), 64'(NR));
    check("midrst_busy", 64'(busy_o), 64'd0);
    repeat (2) step();
    rst_ni = 1'b1;
    step();
    check("midrst_no_emit", 64'(out_valid_o), 64'd0);
    full_block("post_rst", rnd64(), fd);

    // Random keys and blocks
    for (int b = 0; b < 1000; b++) begin
      set_keys(1'b0);
      full_block($sformatf("rand%0d", b), rnd64(), fd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
